// File: rtl/tlc_pkg.sv
// Shared definitions for the four-way traffic-light controller:
// state encoding, lamp patterns and default phase lengths.
package tlc_pkg;

   typedef enum logic [2:0] {
      N_G = 3'd0,
      N_Y = 3'd1,
      S_G = 3'd2,
      S_Y = 3'd3,
      E_G = 3'd4,
      E_Y = 3'd5,
      W_G = 3'd6,
      W_Y = 3'd7
   } tlc_state_e;

   // Lamp order is {red, yellow, green}
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam int DEFAULT_GREEN_CYCLES  = 7;
   localparam int DEFAULT_YELLOW_CYCLES = 2;

   function automatic int tlc_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase-length counter: counts cycles of the current phase and pulses
// phase_done in the last cycle of it, clearing itself for the next phase.
module tlc_phase_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_a,
   input  logic [CNT_W-1:0] len,
   output logic             phase_done,
   output logic [CNT_W-1:0] cnt
);

   // >= rather than == so a stray count above the current length still
   // terminates the phase instead of wrapping through the whole counter.
   assign phase_done = (cnt >= (len - 1'b1));

   always_ff @(posedge clk) begin
      if (!rst_a) begin
         cnt <= '0;
      end else if (phase_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/verilog_bm_224_238.sv
// Four-way traffic-light controller: fixed N->S->E->W rotation with a
// yellow phase after each green; Moore lamp outputs decoded from state.
module verilog_bm_224_238
   import tlc_pkg::*;
#(
   parameter int GREEN_CYCLES  = DEFAULT_GREEN_CYCLES,
   parameter int YELLOW_CYCLES = DEFAULT_YELLOW_CYCLES
) (
   input  logic       clk,
   input  logic       rst_a,
   output logic [2:0] n_lights,
   output logic [2:0] s_lights,
   output logic [2:0] e_lights,
   output logic [2:0] w_lights
);

   localparam int CNT_W = $clog2(tlc_max(GREEN_CYCLES, YELLOW_CYCLES) + 1);

   tlc_state_e       state;
   tlc_state_e       next_state;
   logic [CNT_W-1:0] len_sel;
   logic [CNT_W-1:0] cnt;
   logic             phase_done;

   always_comb begin
      len_sel = CNT_W'(1);
      case (state)
         N_G, S_G, E_G, W_G: len_sel = CNT_W'(GREEN_CYCLES);
         N_Y, S_Y, E_Y, W_Y: len_sel = CNT_W'(YELLOW_CYCLES);
         default:            len_sel = CNT_W'(1);
      endcase
   end

   tlc_phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst_a     (rst_a),
      .len       (len_sel),
      .phase_done(phase_done),
      .cnt       (cnt)
   );

   always_comb begin
      next_state = N_G;
      case (state)
         N_G:     next_state = N_Y;
         N_Y:     next_state = S_G;
         S_G:     next_state = S_Y;
         S_Y:     next_state = E_G;
         E_G:     next_state = E_Y;
         E_Y:     next_state = W_G;
         W_G:     next_state = W_Y;
         W_Y:     next_state = N_G;
         default: next_state = N_G;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_a) begin
         state <= N_G;
      end else if (phase_done) begin
         state <= next_state;
      end
   end

   // Unknown encodings show all red rather than risking a conflicting green
   always_comb begin
      n_lights = LAMP_RED;
      s_lights = LAMP_RED;
      e_lights = LAMP_RED;
      w_lights = LAMP_RED;
      case (state)
         N_G:     n_lights = LAMP_GREEN;
         N_Y:     n_lights = LAMP_YELLOW;
         S_G:     s_lights = LAMP_GREEN;
         S_Y:     s_lights = LAMP_YELLOW;
         E_G:     e_lights = LAMP_GREEN;
         E_Y:     e_lights = LAMP_YELLOW;
         W_G:     w_lights = LAMP_GREEN;
         W_Y:     w_lights = LAMP_YELLOW;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_verilog_bm_224_238.sv
// Bench for the traffic-light controller: default and 1/1-cycle instances
// share clock and reset; expected lamps derive from cycles since reset.
module tb_verilog_bm_224_238;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   always #5 clk = ~clk;

   logic [2:0] n0, s0, e0, w0;
   logic [2:0] n1, s1, e1, w1;

   verilog_bm_224_238 u_dut0 (
      .clk     (clk),
      .rst_a   (rst_a),
      .n_lights(n0),
      .s_lights(s0),
      .e_lights(e0),
      .w_lights(w0)
   );

   verilog_bm_224_238 #(
      .GREEN_CYCLES (1),
      .YELLOW_CYCLES(1)
   ) u_dut1 (
      .clk     (clk),
      .rst_a   (rst_a),
      .n_lights(n1),
      .s_lights(s1),
      .e_lights(e1),
      .w_lights(w1)
   );

   int checks   = 0;
   int failures = 0;
   int t        = 0;
   int cyc      = 0;
   logic [11:0] exp_q[$];
   logic [11:0] exp1_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // t = cycles since the reset edge; position within the rotation picks
   // the lit approach and whether it is in its green or yellow part.
   function automatic logic [11:0] model(input int tt, input int g, input int y);
      int per;
      int p;
      int a;
      int w;
      logic [11:0] r;
      per = g + y;
      p   = tt % (4 * per);
      a   = p / per;
      w   = p % per;
      r   = {4{3'b100}};
      r[(3 - a) * 3 +: 3] = (w < g) ? 3'b001 : 3'b010;
      return r;
   endfunction

   task automatic step(input logic r);
      logic [11:0] e;
      int k;
      @(negedge clk);
      rst_a = r;
      t = r ? t + 1 : 0;
      exp_q.push_back(model(t, 7, 2));
      exp1_q.push_back(model(t, 1, 1));
      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      check("lights_default", {20'd0, n0, s0, e0, w0}, {20'd0, e});
      e = exp1_q.pop_front();
      check("lights_fast", {20'd0, n1, s1, e1, w1}, {20'd0, e});
      k = int'(n0 != 3'b100) + int'(s0 != 3'b100) + int'(e0 != 3'b100) + int'(w0 != 3'b100);
      check("one_nonred", k, 1);
      check("onehot", {28'd0, $onehot(n0), $onehot(s0), $onehot(e0), $onehot(w0)}, 32'hf);
   endtask

   initial begin
      // Reset held for two edges
      step(1'b0);
      check("cnt_after_reset", {29'd0, u_dut0.cnt}, 32'd0);
      step(1'b0);
      check("cnt_after_reset2", {29'd0, u_dut0.cnt}, 32'd0);

      // Full rotation and beyond
      repeat (45) step(1'b1);

      // Reset mid E_G
      step(1'b0);
      repeat (20) step(1'b1);
      step(1'b0);
      check("cnt_after_mid_reset", {29'd0, u_dut0.cnt}, 32'd0);
      repeat (9) step(1'b1);

      // Reset on the would-be N_G -> N_Y transition edge
      step(1'b0);
      repeat (6) step(1'b1);
      check("cnt_at_last_green", {29'd0, u_dut0.cnt}, 32'd6);
      step(1'b0);
      check("cnt_reset_wins", {29'd0, u_dut0.cnt}, 32'd0);
      repeat (10) step(1'b1);

      check("queue_drained", exp_q.size() + exp1_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
